// File: rtl/clock_pkg.sv
// Shared encodings and limits for the digital clock time-keeping block.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/bcd2_mod_cnt.sv
// Two-digit BCD counter wrapping at MOD-1; carry_out flags the wrap increment.
module bcd2_mod_cnt
    import clock_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] lo,
    output logic [3:0] hi,
    output logic       carry_out
);

    localparam logic [3:0] MAX_LO = 4'((MOD - 1) % 10);
    localparam logic [3:0] MAX_HI = 4'((MOD - 1) / 10);

    logic at_max;

    assign at_max    = (hi == MAX_HI) && (lo == MAX_LO);
    assign carry_out = en & at_max;

    always_ff @(posedge in_clk) begin
        if (rst || clr) begin
            lo <= 4'd0;
            hi <= 4'd0;
        end else if (en) begin
            if (at_max) begin
                lo <= 4'd0;
                hi <= 4'd0;
            end else if (lo == 4'd9) begin
                lo <= 4'd0;
                hi <= hi + 4'd1;
            end else begin
                lo <= lo + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping controller: sec/min/hr BCD counters, button edge detect,
// set-time mode FSM with tick timeout, and set-field blink.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOURS_MOD   = 24,
    parameter int unsigned SET_TIMEOUT = 30
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned CNT_W = $clog2(SET_TIMEOUT + 1);

    mode_e            state_q, state_d;
    logic             mode_prev, inc_prev;
    logic             mode_edge, inc_edge, any_edge;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout;
    logic             entering, in_set;
    logic             sec_en, sec_clr, min_en, hr_en;
    logic             sec_carry, min_carry;

    assign mode_edge = btn_mode & ~mode_prev;
    assign inc_edge  = btn_inc & ~inc_prev;
    assign any_edge  = mode_edge | inc_edge;
    assign in_set    = (state_q != MODE_RUN);
    assign timeout   = in_set & tick_1hz & ~any_edge & (to_cnt == CNT_W'(SET_TIMEOUT - 1));
    assign entering  = (state_d != state_q);
    assign mode      = state_q;

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q   <= MODE_RUN;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
        end
    end

    // Mode edge always wins over timeout and over a same-cycle inc edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN:      if (mode_edge) state_d = MODE_SET_HOUR;
            MODE_SET_HOUR: if (mode_edge) state_d = MODE_SET_MIN;
                           else if (timeout) state_d = MODE_RUN;
            MODE_SET_MIN:  if (mode_edge || timeout) state_d = MODE_RUN;
            default:       state_d = MODE_RUN;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            to_cnt <= '0;
            blink  <= 1'b0;
        end else begin
            if (state_d == MODE_RUN || entering || any_edge)
                to_cnt <= '0;
            else if (tick_1hz)
                to_cnt <= to_cnt + CNT_W'(1);

            if (state_d == MODE_RUN || entering)
                blink <= 1'b0;
            else if (tick_1hz)
                blink <= ~blink;
        end
    end

    // Counter steering: carries only ripple while running; set-mode incs never carry.
    assign sec_en  = (state_q == MODE_RUN) & tick_1hz;
    assign sec_clr = in_set & (state_d == MODE_RUN);
    assign min_en  = ((state_q == MODE_RUN) & sec_carry)
                   | ((state_q == MODE_SET_MIN) & inc_edge & ~mode_edge);
    assign hr_en   = ((state_q == MODE_RUN) & min_carry)
                   | ((state_q == MODE_SET_HOUR) & inc_edge & ~mode_edge);

    bcd2_mod_cnt #(.MOD(SEC_MAX + 1)) u_sec (
        .in_clk    (in_clk),
        .rst       (rst),
        .en        (sec_en),
        .clr       (sec_clr),
        .lo        (sec_lo),
        .hi        (sec_hi),
        .carry_out (sec_carry)
    );

    bcd2_mod_cnt #(.MOD(MIN_MAX + 1)) u_min (
        .in_clk    (in_clk),
        .rst       (rst),
        .en        (min_en),
        .clr       (1'b0),
        .lo        (min_lo),
        .hi        (min_hi),
        .carry_out (min_carry)
    );

    bcd2_mod_cnt #(.MOD(HOURS_MOD)) u_hr (
        .in_clk    (in_clk),
        .rst       (rst),
        .en        (hr_en),
        .clr       (1'b0),
        .lo        (hr_lo),
        .hi        (hr_hi),
        .carry_out ()
    );

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_clock_time_ctrl;

    logic       in_clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [1:0] mode;
    logic       blink;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        tick;
        logic        bm;
        logic        bi;
        logic [23:0] t;
        logic [1:0]  m;
        logic        b;
    } vec_t;

    vec_t tbl[13];

    clock_time_ctrl #(.HOURS_MOD(24), .SET_TIMEOUT(30)) dut (
        .in_clk   (in_clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .hr_lo    (hr_lo),
        .hr_hi    (hr_hi),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 in_clk = ~in_clk;

    task automatic drive(input logic t, input logic m, input logic i);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [23:0] et, input logic [1:0] em, input logic eb);
        logic [23:0] got;
        got = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
        compared++;
        if ({got, mode, blink} !== {et, em, eb}) begin
            mismatched++;
            $display("FAIL %s: got time=%h mode=%0d blink=%0b, want time=%h mode=%0d blink=%0b",
                     nm, got, mode, blink, et, em, eb);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0);
        tick_1hz = 1'b0;
    endtask

    task automatic press_mode();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset then 61 ticks
        do_reset();
        chk("reset", 24'h000000, 2'd0, 1'b0);
        ticks(59);
        chk("sec59", 24'h000059, 2'd0, 1'b0);
        ticks(1);
        chk("sec_carry", 24'h000100, 2'd0, 1'b0);
        ticks(1);
        chk("t61", 24'h000101, 2'd0, 1'b0);

        // Table: one cycle per row, starting from 00:01:01 RUN
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'h000102, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 24'h000102, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 24'h000102, 2'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 24'h010102, 2'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 24'h010102, 2'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h010102, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'h010102, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h010102, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 24'h010102, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 24'h010202, 2'd2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 24'h010202, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 24'h010200, 2'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 24'h010201, 2'd0, 1'b0};
        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].tick, tbl[r].bm, tbl[r].bi);
            chk($sformatf("row%0d", r), tbl[r].t, tbl[r].m, tbl[r].b);
        end
        drive(1'b0, 1'b0, 1'b0);

        // Preload 23:59 via set mode, run to 23:59:59, then midnight rollover
        do_reset();
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        chk("preload_min", 24'h235900, 2'd2, 1'b0);
        press_mode();
        chk("preload_run", 24'h235900, 2'd0, 1'b0);
        ticks(59);
        chk("pre_midnight", 24'h235959, 2'd0, 1'b0);
        ticks(1);
        chk("midnight", 24'h000000, 2'd0, 1'b0);

        // Hour wrap in SET_HOUR, frozen time and blink toggling
        do_reset();
        press_mode();
        press_inc(22);
        chk("hr22", 24'h220000, 2'd1, 1'b0);
        press_inc(5);
        chk("hr_wrap", 24'h030000, 2'd1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk($sformatf("blink%0d", k), 24'h030000, 2'd1, 1'((k % 2)));
        end
        tick_1hz = 1'b0;

        // SET_MIN wrap without hour carry, then back to RUN
        press_mode();
        chk("enter_min", 24'h030000, 2'd2, 1'b0);
        press_inc(59);
        chk("min59", 24'h035900, 2'd2, 1'b0);
        press_inc(1);
        chk("min_wrap", 24'h030000, 2'd2, 1'b0);
        press_mode();
        ticks(5);
        chk("run_after_min", 24'h030005, 2'd0, 1'b0);

        // Reset in SET_HOUR with tick and mode edge pending
        press_mode();
        ticks(3);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_mid", 24'h000000, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Timeout after 30 idle ticks; inc edge on tick 29 restarts the count
        do_reset();
        ticks(7);
        press_mode();
        ticks(29);
        chk("to_29", 24'h000007, 2'd1, 1'b1);
        ticks(1);
        chk("to_30", 24'h000000, 2'd0, 1'b0);
        ticks(3);
        press_mode();
        ticks(28);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("to_restart", 24'h010003, 2'd1, 1'b1);
        ticks(29);
        chk("to_restart_29", 24'h010003, 2'd1, 1'b0);
        ticks(1);
        chk("to_restart_30", 24'h010000, 2'd0, 1'b0);

        // Simultaneous edges, then long holds give a single edge each
        do_reset();
        drive(1'b0, 1'b1, 1'b1);
        chk("both_edges", 24'h000000, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) drive(1'b0, 1'b0, 1'b1);
        chk("inc_hold", 24'h010000, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) drive(1'b0, 1'b1, 1'b0);
        chk("mode_hold", 24'h010000, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
